// File: rtl/neuron_layer_ctrl.sv
// Sequences one shared neuron datapath across a layer: clear, stream W_NUM BRAM reads, drain, then hold the result.
// All outputs are registered; po_valid trails po_BRAM_en by BRAM_LAT cycles and RESULT stalls until accepted.
module neuron_layer_ctrl #(
  parameter int W_NUM     = 784,
  parameter int N_NEURONS = 16,
  parameter int BRAM_LAT  = 1,
  parameter int ADDR_W    = 10,
  parameter int IDX_W     = 4
) (
  input  logic              pi_clk,
  input  logic              pi_rst,
  input  logic              pi_start,
  input  logic              pi_result_ready,
  output logic              po_BRAM_en,
  output logic [ADDR_W-1:0] po_BRAM_add,
  output logic              po_valid,
  output logic              po_clc_accumulator,
  output logic              po_accumulation_done,
  output logic [IDX_W-1:0]  po_neuron_idx,
  output logic              po_result_valid,
  output logic              po_busy,
  output logic              po_done
);

  typedef enum logic [2:0] {
    IDLE, CLEAR, STREAM, DRAIN, ACC_DONE, RESULT, FINISH
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(W_NUM - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(N_NEURONS - 1);
  localparam logic [1:0]        DRAIN_LAST = 2'(BRAM_LAT - 1);

  state_t              state, state_n;
  logic [ADDR_W-1:0]   addr_n;
  logic [IDX_W-1:0]    idx_n;
  logic [1:0]          drain_cnt, drain_cnt_n;
  logic [BRAM_LAT-1:0] valid_sr;

  always_comb begin
    state_n     = state;
    addr_n      = po_BRAM_add;
    idx_n       = po_neuron_idx;
    drain_cnt_n = drain_cnt;
    case (state)
      IDLE: begin
        if (pi_start) begin
          state_n = CLEAR;
          idx_n   = '0;
        end
      end
      CLEAR: begin
        state_n = STREAM;
        addr_n  = '0;
      end
      STREAM: begin
        // Address parks at 0 on exit so the next CLEAR already presents 0.
        if (po_BRAM_add == ADDR_LAST) begin
          state_n     = DRAIN;
          addr_n      = '0;
          drain_cnt_n = '0;
        end else begin
          addr_n = po_BRAM_add + ADDR_W'(1);
        end
      end
      DRAIN: begin
        if (drain_cnt == DRAIN_LAST) begin
          state_n = ACC_DONE;
        end else begin
          drain_cnt_n = drain_cnt + 2'd1;
        end
      end
      ACC_DONE: state_n = RESULT;
      RESULT: begin
        if (pi_result_ready) begin
          if (po_neuron_idx == IDX_LAST) begin
            state_n = FINISH;
          end else begin
            state_n = CLEAR;
            idx_n   = po_neuron_idx + IDX_W'(1);
          end
        end
      end
      FINISH: begin
        state_n = IDLE;
        idx_n   = '0;
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every one of them comes straight off a flop.
  always_ff @(posedge pi_clk or negedge pi_rst) begin
    if (!pi_rst) begin
      state                <= IDLE;
      po_BRAM_add          <= '0;
      po_neuron_idx        <= '0;
      drain_cnt            <= '0;
      po_BRAM_en           <= 1'b0;
      po_clc_accumulator   <= 1'b0;
      po_accumulation_done <= 1'b0;
      po_result_valid      <= 1'b0;
      po_busy              <= 1'b0;
      po_done              <= 1'b0;
      valid_sr             <= '0;
    end else begin
      state                <= state_n;
      po_BRAM_add          <= addr_n;
      po_neuron_idx        <= idx_n;
      drain_cnt            <= drain_cnt_n;
      po_BRAM_en           <= (state_n == STREAM);
      po_clc_accumulator   <= (state_n == CLEAR);
      po_accumulation_done <= (state_n == ACC_DONE);
      po_result_valid      <= (state_n == RESULT);
      po_busy              <= (state_n != IDLE);
      po_done              <= (state_n == FINISH);
      valid_sr[0]          <= po_BRAM_en;
      for (int i = 1; i < BRAM_LAT; i++) begin
        valid_sr[i] <= valid_sr[i-1];
      end
    end
  end

  assign po_valid = valid_sr[BRAM_LAT-1];

endmodule

// File: tb/tb_neuron_layer_ctrl.sv
// Scoreboard bench: stimulus pushes expected (instance, cycle, value) events per output kind; a monitor pops on each DUT event.
module tb_neuron_layer_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [3:0]       rst_n, start, ready;
  logic [3:0]       en, valid, clc, accd, rv, busy, done;
  logic [3:0][9:0]  add;
  logic [3:0][3:0]  idx;

  int total = 0;
  int bad   = 0;

  typedef struct {int inst; int cyc; int val;} ev_t;
  ev_t q_clc[$], q_en[$], q_val[$], q_accd[$], q_acc[$], q_done[$];
  int vcnt[4], clcn[4], accdn[4], accn[4], donen[4], done_cyc[4];

  // a: single neuron, b: two neurons, c: full default layer, d: two neurons with 3-cycle BRAM
  neuron_layer_ctrl #(.W_NUM(4), .N_NEURONS(1), .BRAM_LAT(1), .ADDR_W(10), .IDX_W(4)) u_a (
    .pi_clk(clk), .pi_rst(rst_n[0]), .pi_start(start[0]), .pi_result_ready(ready[0]),
    .po_BRAM_en(en[0]), .po_BRAM_add(add[0]), .po_valid(valid[0]), .po_clc_accumulator(clc[0]),
    .po_accumulation_done(accd[0]), .po_neuron_idx(idx[0]), .po_result_valid(rv[0]),
    .po_busy(busy[0]), .po_done(done[0]));
  neuron_layer_ctrl #(.W_NUM(4), .N_NEURONS(2), .BRAM_LAT(1), .ADDR_W(10), .IDX_W(4)) u_b (
    .pi_clk(clk), .pi_rst(rst_n[1]), .pi_start(start[1]), .pi_result_ready(ready[1]),
    .po_BRAM_en(en[1]), .po_BRAM_add(add[1]), .po_valid(valid[1]), .po_clc_accumulator(clc[1]),
    .po_accumulation_done(accd[1]), .po_neuron_idx(idx[1]), .po_result_valid(rv[1]),
    .po_busy(busy[1]), .po_done(done[1]));
  neuron_layer_ctrl #(.W_NUM(784), .N_NEURONS(16), .BRAM_LAT(1), .ADDR_W(10), .IDX_W(4)) u_c (
    .pi_clk(clk), .pi_rst(rst_n[2]), .pi_start(start[2]), .pi_result_ready(ready[2]),
    .po_BRAM_en(en[2]), .po_BRAM_add(add[2]), .po_valid(valid[2]), .po_clc_accumulator(clc[2]),
    .po_accumulation_done(accd[2]), .po_neuron_idx(idx[2]), .po_result_valid(rv[2]),
    .po_busy(busy[2]), .po_done(done[2]));
  neuron_layer_ctrl #(.W_NUM(4), .N_NEURONS(2), .BRAM_LAT(3), .ADDR_W(10), .IDX_W(4)) u_d (
    .pi_clk(clk), .pi_rst(rst_n[3]), .pi_start(start[3]), .pi_result_ready(ready[3]),
    .po_BRAM_en(en[3]), .po_BRAM_add(add[3]), .po_valid(valid[3]), .po_clc_accumulator(clc[3]),
    .po_accumulation_done(accd[3]), .po_neuron_idx(idx[3]), .po_result_valid(rv[3]),
    .po_busy(busy[3]), .po_done(done[3]));

  function automatic string kname(input int kind);
    case (kind)
      0: return "clc";
      1: return "bram_en";
      2: return "valid";
      3: return "acc_done";
      4: return "accept";
      default: return "done";
    endcase
  endfunction

  function automatic logic [20:0] outs(input int k);
    return {en[k], valid[k], clc[k], accd[k], rv[k], busy[k], done[k], add[k], idx[k]};
  endfunction

  task automatic push(input int kind, input int k, input int c, input int v);
    ev_t e;
    e.inst = k; e.cyc = c; e.val = v;
    case (kind)
      0: q_clc.push_back(e);
      1: q_en.push_back(e);
      2: q_val.push_back(e);
      3: q_accd.push_back(e);
      4: q_acc.push_back(e);
      default: q_done.push_back(e);
    endcase
  endtask

  // Expected event timeline of one layer started by pi_start high in cycle s; stall0 extends neuron 0's RESULT.
  task automatic expect_layer(input int k, input int s, input int w, input int n, input int l, input int stall0);
    int t, acc;
    t = s + 1;
    for (int i = 0; i < n; i++) begin
      push(0, k, t, i);
      for (int a = 0; a < w; a++) push(1, k, t + 1 + a, a);
      for (int a = 0; a < w; a++) push(2, k, t + 1 + a + l, -1);
      push(3, k, t + 1 + w + l, i);
      acc = t + 2 + w + l + ((i == 0) ? stall0 : 0);
      push(4, k, acc, i);
      t = acc + 1;
    end
    push(5, k, t, -1);
  endtask

  task automatic got(input int kind, input int k, input int v);
    ev_t e;
    bit  have;
    have = 1'b0;
    case (kind)
      0: if (q_clc.size()  != 0) begin e = q_clc.pop_front();  have = 1'b1; end
      1: if (q_en.size()   != 0) begin e = q_en.pop_front();   have = 1'b1; end
      2: if (q_val.size()  != 0) begin e = q_val.pop_front();  have = 1'b1; end
      3: if (q_accd.size() != 0) begin e = q_accd.pop_front(); have = 1'b1; end
      4: if (q_acc.size()  != 0) begin e = q_acc.pop_front();  have = 1'b1; end
      default: if (q_done.size() != 0) begin e = q_done.pop_front(); have = 1'b1; end
    endcase
    total++;
    if (!have) begin
      bad++;
      $display("FAIL %s inst%0d: got event at cycle %0d val %0d, want no event", kname(kind), k, cyc, v);
    end else if (e.inst != k || e.cyc != cyc || (e.val >= 0 && e.val != v)) begin
      bad++;
      $display("FAIL %s: got inst%0d cycle %0d val %0d, want inst%0d cycle %0d val %0d",
               kname(kind), k, cyc, v, e.inst, e.cyc, e.val);
    end
  endtask

  task automatic monitor();
    for (int k = 0; k < 4; k++) begin
      vcnt[k] = 0; clcn[k] = 0; accdn[k] = 0; accn[k] = 0; donen[k] = 0; done_cyc[k] = 0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (clc[k])   begin clcn[k]++;  got(0, k, int'(idx[k])); end
        if (en[k])    got(1, k, int'(add[k]));
        if (valid[k]) begin vcnt[k]++;  got(2, k, 0); end
        if (accd[k])  begin accdn[k]++; got(3, k, int'(idx[k])); end
        if (rv[k] && ready[k]) begin accn[k]++; got(4, k, int'(idx[k])); end
        if (done[k])  begin donen[k]++; done_cyc[k] = cyc; got(5, k, 0); end
      end
    end
  endtask

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic check_empty(input string nm);
    int n;
    n = q_clc.size() + q_en.size() + q_val.size() + q_accd.size() + q_acc.size() + q_done.size();
    check({nm, " pending events"}, n, 0);
    q_clc.delete(); q_en.delete(); q_val.delete(); q_accd.delete(); q_acc.delete(); q_done.delete();
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int s, b0, b1, b2, b3;
    rst_n = '0; start = '0; ready = '0;
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1;
    rst_n = '1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) check($sformatf("reset outputs inst%0d", k), int'(outs(k)), 0);
    tick(1);

    // single neuron, ready tied high
    ready[0] = 1'b1;
    b0 = vcnt[0];
    s = cyc; start[0] = 1'b1;
    expect_layer(0, s, 4, 1, 1, 0);
    tick(1); start[0] = 1'b0;
    tick(12);
    check_empty("single");
    check("single valid count", vcnt[0] - b0, 4);
    check("single busy after done", int'(busy[0]), 0);

    // start held high through FINISH restarts on the first IDLE cycle
    s = cyc; start[0] = 1'b1;
    expect_layer(0, s, 4, 1, 1, 0);
    expect_layer(0, s + 10, 4, 1, 1, 0);
    tick(11); start[0] = 1'b0;
    tick(12);
    check_empty("held start");

    // backpressure: ready low for 10 RESULT cycles on neuron 0
    ready[1] = 1'b0;
    s = cyc; start[1] = 1'b1;
    expect_layer(1, s, 4, 2, 1, 10);
    tick(1); start[1] = 1'b0;
    tick(7);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("stall%0d result_valid", i), int'(rv[1]), 1);
      check($sformatf("stall%0d idx", i), int'(idx[1]), 0);
      check($sformatf("stall%0d busy", i), int'(busy[1]), 1);
      @(posedge clk); #1;
    end
    ready[1] = 1'b1;
    tick(15);
    check_empty("backpressure");

    // reset in the middle of STREAM at address 100
    ready[2] = 1'b1;
    s = cyc; start[2] = 1'b1;
    push(0, 2, s + 1, 0);
    for (int a = 0; a <= 100; a++) push(1, 2, s + 2 + a, a);
    for (int a = 0; a < 100; a++) push(2, 2, s + 3 + a, -1);
    tick(1); start[2] = 1'b0;
    tick(101);
    check("abort address before reset", int'(add[2]), 100);
    @(negedge clk); #1;
    rst_n[2] = 1'b0;
    #1;
    check("async reset outputs", int'(outs(2)), 0);
    tick(3); rst_n[2] = 1'b1;
    tick(20);
    check_empty("reset abort");

    // full default layer after the aborted one
    b0 = vcnt[2]; b1 = clcn[2]; b2 = accdn[2]; b3 = accn[2];
    s = cyc; start[2] = 1'b1;
    expect_layer(2, s, 784, 16, 1, 0);
    tick(1); start[2] = 1'b0;
    tick(12620);
    check_empty("full layer");
    check("full valid count", vcnt[2] - b0, 12544);
    check("full clc count", clcn[2] - b1, 16);
    check("full acc_done count", accdn[2] - b2, 16);
    check("full accept count", accn[2] - b3, 16);
    check("full layer latency", done_cyc[2] - (s + 1) + 1, 12609);

    // BRAM_LAT=3, start pulses during STREAM and RESULT are ignored
    ready[3] = 1'b0;
    b0 = donen[3];
    s = cyc; start[3] = 1'b1;
    expect_layer(3, s, 4, 2, 3, 3);
    tick(1); start[3] = 1'b0;
    tick(2); start[3] = 1'b1;
    tick(1); start[3] = 1'b0;
    tick(7); start[3] = 1'b1;
    tick(1); start[3] = 1'b0;
    tick(1); ready[3] = 1'b1;
    tick(25);
    check_empty("ignored start");
    check("ignored start done count", donen[3] - b0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
